// File: rtl/start_cap_ctrl.sv
// Capture-start controller: turns a software control word into a bounded burst of
// capture-buffer writes, optionally gated by a frame sync, with abort and sticky done.
module start_cap_ctrl #(
  parameter int LEN_W = 20
) (
  input  logic             user_clk,
  input  logic             user_rst_n,
  input  logic [31:0]      start_cap_reg,
  input  logic             sync_in,
  output logic             cap_we,
  output logic [LEN_W-1:0] cap_addr,
  output logic             busy,
  output logic             done,
  output logic [31:0]      status_out
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t           state, state_nxt;
  logic             start_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] wr_cnt;
  logic [31:0]      status_nxt;

  logic             start_bit, wait_sync, abort;
  logic [LEN_W-1:0] len_field;
  logic             start_edge, accept, last_wr, armed;
  logic             unused_ctrl_bits;

  assign start_bit        = start_cap_reg[0];
  assign wait_sync        = start_cap_reg[1];
  assign abort            = start_cap_reg[2];
  assign len_field        = start_cap_reg[31 -: LEN_W];
  assign unused_ctrl_bits = ^start_cap_reg[31-LEN_W:3];

  assign start_edge = start_bit & ~start_d;
  assign accept     = start_edge && (state == IDLE || state == DONE);
  // len_q is never zero while in CAPTURE, so the subtraction cannot underflow here
  assign last_wr    = (cap_addr == len_q - LEN_W'(1));

  assign cap_we = (state == CAPTURE);
  assign armed  = (state == ARMED);
  assign busy   = (state == ARMED) || (state == CAPTURE);
  assign done   = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start_edge) begin
          if (wait_sync)              state_nxt = ARMED;
          else if (len_field == '0)   state_nxt = DONE;
          else                        state_nxt = CAPTURE;
        end
      end
      ARMED: begin
        // abort outranks a coincident sync pulse
        if (abort)                    state_nxt = IDLE;
        else if (sync_in)             state_nxt = (len_q == '0) ? DONE : CAPTURE;
      end
      CAPTURE: begin
        if (abort)                    state_nxt = IDLE;
        else if (last_wr)             state_nxt = DONE;
      end
      default:                        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    status_nxt              = '0;
    status_nxt[31]          = done;
    status_nxt[30]          = busy;
    status_nxt[29]          = armed;
    status_nxt[LEN_W-1:0]   = wr_cnt;
  end

  // state / address / status register stage
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state      <= IDLE;
      start_d    <= 1'b0;
      len_q      <= '0;
      cap_addr   <= '0;
      wr_cnt     <= '0;
      status_out <= '0;
    end else begin
      state      <= state_nxt;
      start_d    <= start_bit;
      status_out <= status_nxt;
      if (accept) begin
        len_q    <= len_field;
        cap_addr <= '0;
        wr_cnt   <= '0;
      end else if (state == CAPTURE) begin
        cap_addr <= cap_addr + LEN_W'(1);
        wr_cnt   <= wr_cnt + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_start_cap_ctrl.sv
// Directed bench for start_cap_ctrl: immediate capture, sync wait, abort, zero length,
// re-arm attempts and asynchronous reset mid-capture.
module tb_start_cap_ctrl;

  logic        user_clk = 1'b0;
  logic        user_rst_n;
  logic [31:0] start_cap_reg;
  logic        sync_in;
  logic        cap_we;
  logic [19:0] cap_addr;
  logic        busy;
  logic        done;
  logic [31:0] status_out;

  int checks = 0;
  int errors = 0;

  start_cap_ctrl #(.LEN_W(20)) dut (
    .user_clk      (user_clk),
    .user_rst_n    (user_rst_n),
    .start_cap_reg (start_cap_reg),
    .sync_in       (sync_in),
    .cap_we        (cap_we),
    .cap_addr      (cap_addr),
    .busy          (busy),
    .done          (done),
    .status_out    (status_out)
  );

  always #5 user_clk = ~user_clk;

  function automatic logic [31:0] word(input logic [19:0] len, input logic ws,
                                       input logic ab, input logic st);
    return {len, 9'b0, ab, ws, st};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  initial begin
    user_rst_n    = 1'b0;
    start_cap_reg = '0;
    sync_in       = 1'b0;
    step();
    step();
    chk("rst_cap_we", {31'b0, cap_we}, 32'd0);
    chk("rst_busy",   {31'b0, busy},   32'd0);
    chk("rst_done",   {31'b0, done},   32'd0);
    chk("rst_addr",   {12'b0, cap_addr}, 32'd0);
    chk("rst_status", status_out, 32'd0);
    user_rst_n = 1'b1;
    step();

    // immediate capture, length 4
    start_cap_reg = word(20'd4, 1'b0, 1'b0, 1'b1);
    chk("imm_pre_we", {31'b0, cap_we}, 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("imm_we",   {31'b0, cap_we}, 32'd1);
      chk("imm_addr", {12'b0, cap_addr}, i);
      step();
    end
    chk("imm_we_off", {31'b0, cap_we}, 32'd0);
    chk("imm_done",   {31'b0, done},   32'd1);
    chk("imm_busy",   {31'b0, busy},   32'd0);
    chk("imm_addr_hold", {12'b0, cap_addr}, 32'd4);
    chk("imm_status_lag", status_out, 32'h4000_0003);
    step();
    chk("imm_status", status_out, 32'h8000_0004);

    // sync wait, length 3
    start_cap_reg = word(20'd3, 1'b1, 1'b0, 1'b0);
    step();
    start_cap_reg = word(20'd3, 1'b1, 1'b0, 1'b1);
    step();
    chk("sync_busy", {31'b0, busy}, 32'd1);
    chk("sync_done_clr", {31'b0, done}, 32'd0);
    for (int i = 0; i < 9; i++) begin
      chk("sync_wait_we", {31'b0, cap_we}, 32'd0);
      step();
    end
    chk("sync_wait_busy", {31'b0, busy}, 32'd1);
    chk("sync_status_armed", status_out, 32'h6000_0000);
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sync_we",   {31'b0, cap_we}, 32'd1);
      chk("sync_addr", {12'b0, cap_addr}, i);
      step();
    end
    chk("sync_done", {31'b0, done}, 32'd1);
    chk("sync_we_off", {31'b0, cap_we}, 32'd0);

    // abort at the 5th write of a length-100 capture
    start_cap_reg = word(20'd100, 1'b0, 1'b0, 1'b0);
    step();
    start_cap_reg = word(20'd100, 1'b0, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 4; i++) step();
    chk("abort_addr4", {12'b0, cap_addr}, 32'd4);
    chk("abort_we4", {31'b0, cap_we}, 32'd1);
    start_cap_reg = word(20'd100, 1'b0, 1'b1, 1'b1);
    step();
    start_cap_reg = word(20'd100, 1'b0, 1'b0, 1'b1);
    chk("abort_we_off", {31'b0, cap_we}, 32'd0);
    chk("abort_busy",   {31'b0, busy},   32'd0);
    chk("abort_done",   {31'b0, done},   32'd0);
    step();
    chk("abort_status_cnt", status_out, 32'd5);

    // abort beats a coincident sync pulse in ARMED
    start_cap_reg = word(20'd2, 1'b1, 1'b0, 1'b0);
    step();
    start_cap_reg = word(20'd2, 1'b1, 1'b0, 1'b1);
    step();
    chk("armabort_busy_pre", {31'b0, busy}, 32'd1);
    start_cap_reg = word(20'd2, 1'b1, 1'b1, 1'b1);
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    chk("armabort_we",   {31'b0, cap_we}, 32'd0);
    chk("armabort_busy", {31'b0, busy},   32'd0);
    chk("armabort_done", {31'b0, done},   32'd0);

    // zero length from IDLE
    start_cap_reg = word(20'd0, 1'b0, 1'b0, 1'b0);
    step();
    start_cap_reg = word(20'd0, 1'b0, 1'b0, 1'b1);
    chk("zero_done_pre", {31'b0, done}, 32'd0);
    step();
    chk("zero_done", {31'b0, done},   32'd1);
    chk("zero_we",   {31'b0, cap_we}, 32'd0);
    chk("zero_busy", {31'b0, busy},   32'd0);
    step();
    chk("zero_status", status_out, 32'h8000_0000);

    // re-arm attempt during CAPTURE is ignored; new edge in DONE restarts
    start_cap_reg = word(20'd3, 1'b0, 1'b0, 1'b0);
    step();
    start_cap_reg = word(20'd3, 1'b0, 1'b0, 1'b1);
    step();
    start_cap_reg = word(20'd3, 1'b0, 1'b0, 1'b0);
    step();
    start_cap_reg = word(20'd3, 1'b0, 1'b0, 1'b1);
    step();
    chk("rearm_we",   {31'b0, cap_we}, 32'd1);
    chk("rearm_addr", {12'b0, cap_addr}, 32'd2);
    step();
    chk("rearm_done", {31'b0, done}, 32'd1);
    chk("rearm_addr_final", {12'b0, cap_addr}, 32'd3);
    step();
    chk("rearm_status", status_out, 32'h8000_0003);
    start_cap_reg = word(20'd3, 1'b0, 1'b0, 1'b0);
    step();
    start_cap_reg = word(20'd3, 1'b0, 1'b0, 1'b1);
    step();
    chk("restart_done_clr", {31'b0, done}, 32'd0);
    chk("restart_we",   {31'b0, cap_we}, 32'd1);
    chk("restart_addr", {12'b0, cap_addr}, 32'd0);
    step();
    step();
    step();
    chk("restart_done", {31'b0, done}, 32'd1);

    // async reset at the 2nd write, start held high through release
    start_cap_reg = word(20'd8, 1'b0, 1'b0, 1'b0);
    step();
    start_cap_reg = word(20'd8, 1'b0, 1'b0, 1'b1);
    step();
    step();
    chk("ares_we_pre", {31'b0, cap_we}, 32'd1);
    chk("ares_addr_pre", {12'b0, cap_addr}, 32'd1);
    #2 user_rst_n = 1'b0;
    #1;
    chk("ares_we",     {31'b0, cap_we}, 32'd0);
    chk("ares_busy",   {31'b0, busy},   32'd0);
    chk("ares_done",   {31'b0, done},   32'd0);
    chk("ares_addr",   {12'b0, cap_addr}, 32'd0);
    chk("ares_status", status_out, 32'd0);
    #2 user_rst_n = 1'b1;
    step();
    chk("ares_restart_we",   {31'b0, cap_we}, 32'd1);
    chk("ares_restart_addr", {12'b0, cap_addr}, 32'd0);
    step();
    chk("ares_restart_addr1", {12'b0, cap_addr}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
